hilo_sequencer: RTL
===================

HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO register width; only 32 is verified.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 issue  input  1  ID stage presents an RHilo-category instruction this cycle.
REQ-005 func  input  6  funct field of the issued instruction.
REQ-006 rsData  input  WIDTH  rs operand (dividend / multiplicand / MTHI / MTLO source).
REQ-007 rtData  input  WIDTH  rt operand (divisor / multiplier).
REQ-008 flush  input  1  pipeline flush; cancels any in-flight operation.
REQ-009 stall  output  1  combinational; holds the issuing stage this cycle.
REQ-010 readData  output  WIDTH  combinational HI (MFHI) or LO (MFLO) value; all zeros otherwise.
REQ-011 busy  output  1  an iterative operation is in flight.
REQ-012 done  output  1  one-cycle pulse in the cycle after HI/LO are written by MULT/MULTU/DIV/DIVU.

Function
REQ-013 Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011; any other funct with issue high is ignored (no stall, no state change).
REQ-014 stall = issue && recognised funct && (state != IDLE); an instruction is accepted on an edge where issue is high, stall is low and flush is low.
REQ-015 States: IDLE, MUL, DIV, FIX; transitions occur only on clock edges.
REQ-016 IDLE: accepted MTHI/MTLO writes rsData to HI/LO at that edge; accepted MFHI/MFLO drives readData from HI/LO in the same cycle; the state stays IDLE.
REQ-017 IDLE: accepted MULT/MULTU -> MUL, accepted DIV/DIVU -> DIV; operands are latched as magnitudes (absolute value for signed ops, 0x80000000 taken as unsigned 2^31); result signs and the op kind are recorded; counter = 0.
REQ-018 MUL: one shift-add step per cycle; after 32 steps (counter 31) -> FIX.
REQ-019 DIV: one restoring shift-subtract step per cycle; after 32 steps -> FIX.
REQ-020 FIX: writes HI/LO, applying the sign correction; -> IDLE. done is high the following cycle.
REQ-021 Latency: accept at edge E0; HI/LO are written at edge E33; busy is high in the cycles after E0 through E33; a stalled MF*/MT* is accepted at the first edge after E33.
REQ-022 MULT signed: {HI,LO} = 64-bit product, negated if the operand signs differ; MULTU: no negation.
REQ-023 DIV signed: LO = quotient, negated if the signs differ; HI = remainder with the sign of the dividend; DIVU: no correction.
REQ-024 Divide by zero (rtData == 0 on accept): no iteration; IDLE -> FIX at E0, then at E1 LO = all ones and HI = rsData; done pulses after E1.
REQ-025 flush in any state: next state IDLE, HI/LO unchanged, no done pulse, pending accept dropped; flush takes priority over issue.
REQ-026 MT* or MF* issued while busy: stall; HI/LO are never partially updated.

Reset
REQ-027 reset high at an edge: state IDLE, HI = LO = 0, counter = 0, latched operands = 0, done = 0; reset has priority over flush and issue.
REQ-028 Mid-operation reset aborts the operation; busy and stall are low in the cycle after the reset edge.

Structure
REQ-029 A shared package holds the funct-code constants, the state enumeration, and the 6-bit counter width constant.
REQ-030 One sub-module, hilo_step: combinational single iteration (shift-add or shift-subtract selected by mode), instantiated once; the FSM, counter and HI/LO registers stay in hilo_sequencer.

Verification
REQ-031 MULT rs=0xFFFFFFFE (-2), rt=3 -> after E33 HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulses once.
REQ-032 DIV rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU rs=7, rt=2 -> LO=3, HI=1.
REQ-033 MFLO issued 5 cycles after MULTU 0xFFFFFFFF*0xFFFFFFFF -> stall held until E33; accepted next edge with readData=0x00000001; HI=0xFFFFFFFE.
REQ-034 DIVU rs=0x1234, rt=0 -> at E1 LO=0xFFFFFFFF, HI=0x1234; busy for exactly one cycle.
REQ-035 MTHI 0xA5A5A5A5, then MULT, flush at cycle 10 -> IDLE next cycle; MFHI returns 0xA5A5A5A5; no done pulse.
REQ-036 reset asserted at cycle 20 of a DIV -> HI=LO=0, busy=0, stall=0 the next cycle; an immediately following MTLO 0x5 is accepted without stall.

Source files
------------

// File: rtl/hilo_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: funct codes,
// FSM states and counter width.
package hilo_sequencer_pkg;

  localparam int CNT_W = 6;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  function automatic logic fn_known(input logic [5:0] f);
    return (f == FN_MFHI) || (f == FN_MTHI) || (f == FN_MFLO) || (f == FN_MTLO) ||
           (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/hilo_sequencer_step.sv
// One combinational iteration: shift-add multiply (mode=0) or restoring
// shift-subtract divide (mode=1) on the {acc_hi, acc_lo} pair.
module hilo_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    hi_next = '0;
    lo_next = '0;
    if (!mode) begin
      // Multiplier bits shift out of acc_lo as product bits shift in.
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], acc_lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      hi_next = diff[WIDTH-1:0];
      lo_next = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_next = shifted[WIDTH-1:0];
      lo_next = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_sequencer.sv
// HI/LO unit: MT*/MF* in one cycle, MULT/DIV over 32 iterations plus a fix-up
// cycle (33 edges); recognised instructions stall while an operation is in flight.
module hilo_sequencer
  import hilo_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rsData,
  input  logic [WIDTH-1:0] rtData,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] readData,
  output logic             busy,
  output logic             done
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
  logic               neg_q, neg_r, is_div, div_zero, done_q;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               known, accept, signed_op;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod, prod_fix;

  hilo_step #(.WIDTH(WIDTH)) u_step (
    .mode    (state == ST_DIV),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .opnd    (opnd),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_comb begin
    known     = issue && fn_known(func);
    accept    = known && (state == ST_IDLE) && !flush;
    stall     = known && (state != ST_IDLE);
    busy      = (state != ST_IDLE);
    done      = done_q;
    signed_op = !func[0];
    // Negating 0x80000000 leaves 0x80000000, which reads correctly as 2^31.
    rs_mag    = (signed_op && rsData[WIDTH-1]) ? -rsData : rsData;
    rt_mag    = (signed_op && rtData[WIDTH-1]) ? -rtData : rtData;
    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_q ? -prod : prod;
    readData  = '0;
    if (accept && func == FN_MFHI) readData = hi;
    if (accept && func == FN_MFLO) readData = lo;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && (func == FN_MULT || func == FN_MULTU)) begin
          state_nxt = ST_MUL;
        end else if (accept && (func == FN_DIV || func == FN_DIVU)) begin
          state_nxt = (rtData == '0) ? ST_FIX : ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == ST_FIX) && !flush;
      if (!flush) begin
        case (state)
          ST_IDLE: begin
            if (accept && func == FN_MTHI) hi <= rsData;
            if (accept && func == FN_MTLO) lo <= rsData;
            if (accept && (func == FN_MULT || func == FN_MULTU)) begin
              acc_hi   <= '0;
              acc_lo   <= rt_mag;
              opnd     <= rs_mag;
              neg_q    <= signed_op && (rsData[WIDTH-1] ^ rtData[WIDTH-1]);
              neg_r    <= 1'b0;
              is_div   <= 1'b0;
              div_zero <= 1'b0;
              cnt      <= '0;
            end
            if (accept && (func == FN_DIV || func == FN_DIVU)) begin
              is_div   <= 1'b1;
              cnt      <= '0;
              opnd     <= rt_mag;
              neg_q    <= signed_op && (rsData[WIDTH-1] ^ rtData[WIDTH-1]);
              neg_r    <= signed_op && rsData[WIDTH-1];
              div_zero <= (rtData == '0);
              // A zero divisor preloads the final HI/LO values directly.
              acc_hi   <= (rtData == '0) ? rsData : '0;
              acc_lo   <= (rtData == '0) ? '1 : rs_mag;
            end
          end
          ST_MUL, ST_DIV: begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CNT_W'(1);
          end
          ST_FIX: begin
            if (div_zero) begin
              hi <= acc_hi;
              lo <= acc_lo;
            end else if (is_div) begin
              hi <= neg_r ? -acc_hi : acc_hi;
              lo <= neg_q ? -acc_lo : acc_lo;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
